// File: rtl/sample_mem_arbiter.sv
// sample_mem_arbiter
//   Shares one single-port synchronous sample RAM (the delay/echo line)
//   between the effect write path (port 0) and the tap-read path (port 1).
//   Ownership is round-robin with a burst limit. The RAM command is
//   registered. A tag travels with every read so the returning data can be
//   steered to the port that asked for it.
//
// Ports
//   clk, reset_n          effect-domain clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0 port 0 request. Held stable until accepted.
//   gnt0                  port 0 grant. req0 & gnt0 at a rising edge = beat accepted.
//   rvalid0/rdata0        port 0 read return: one-cycle pulse, data from mem_rdata
//   req1 ... rdata1       the same set of signals for port 1
//   mem_en/mem_we         RAM enable / write enable
//   mem_addr/mem_wdata    RAM address / write data
//   mem_rdata             RAM read data, valid one cycle after a read command
//
// Beat timeline for a beat accepted at edge E:
//   E   : capture stage loads the beat
//   E+1 : command register presents the beat to the RAM
//   E+2 : RAM data appears and the tagged rvalid pulse is raised
module sample_mem_arbiter #(
  parameter int addr_width = 15,
  parameter int d_width    = 16,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [d_width-1:0]    wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [d_width-1:0]    rdata0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [d_width-1:0]    wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [d_width-1:0]    rdata1,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [d_width-1:0]    mem_wdata,
  input  logic [d_width-1:0]    mem_rdata
);

  localparam int cnt_w = $clog2(max_burst) + 1;
  localparam logic [cnt_w-1:0] burst_limit = cnt_w'(max_burst);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [cnt_w-1:0] burst_cnt, burst_cnt_nxt, cnt_inc;
  logic             last_owner, last_owner_nxt;

  logic             acc0, acc1, acc_any;

  // Capture stage: the beat accepted at the most recent edge.
  logic                  beat_valid;
  logic                  beat_we;
  logic                  beat_tag;
  logic [addr_width-1:0] beat_addr;
  logic [d_width-1:0]    beat_wdata;

  // Read tag that travels alongside the command register.
  logic                  cmd_rd;
  logic                  cmd_tag;

  // The state itself is a register, so the grants are registered too.
  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

  assign acc0    = gnt0 & req0;
  assign acc1    = gnt1 & req1;
  assign acc_any = acc0 | acc1;

  assign cnt_inc = burst_cnt + cnt_w'(1);

  // Next-state and burst bookkeeping.
  // A burst of max_burst beats hands ownership to the other port only if
  // that port is requesting. Otherwise the owner keeps going with a new
  // burst. Dropping req always ends ownership, even on the limit beat.
  // last_owner records the port that most recently gave up ownership, so
  // a tie seen in IDLE goes to the other port.
  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (req0 && req1) begin
          state_nxt = last_owner ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_nxt      = req1 ? OWN1 : IDLE;
          burst_cnt_nxt  = '0;
          last_owner_nxt = 1'b0;
        end else if (cnt_inc == burst_limit) begin
          burst_cnt_nxt = '0;
          if (req1) begin
            state_nxt      = OWN1;
            last_owner_nxt = 1'b0;
          end
        end else begin
          burst_cnt_nxt = cnt_inc;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_nxt      = req0 ? OWN0 : IDLE;
          burst_cnt_nxt  = '0;
          last_owner_nxt = 1'b1;
        end else if (cnt_inc == burst_limit) begin
          burst_cnt_nxt = '0;
          if (req0) begin
            state_nxt      = OWN0;
            last_owner_nxt = 1'b1;
          end
        end else begin
          burst_cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Arbitration state. last_owner resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Capture the accepted beat. The payload is held when no beat is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_valid <= 1'b0;
      beat_we    <= 1'b0;
      beat_tag   <= 1'b0;
      beat_addr  <= '0;
      beat_wdata <= '0;
    end else begin
      beat_valid <= acc_any;
      if (acc_any) begin
        beat_we    <= acc1 ? we1    : we0;
        beat_tag   <= acc1;
        beat_addr  <= acc1 ? addr1  : addr0;
        beat_wdata <= acc1 ? wdata1 : wdata0;
      end
    end
  end

  // Registered RAM command. Address and data keep their last values on
  // idle cycles, so the RAM pins only change when a real beat is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_rd    <= 1'b0;
      cmd_tag   <= 1'b0;
    end else begin
      mem_en  <= beat_valid;
      mem_we  <= beat_valid & beat_we;
      cmd_rd  <= beat_valid & ~beat_we;
      cmd_tag <= beat_tag;
      if (beat_valid) begin
        mem_addr  <= beat_addr;
        mem_wdata <= beat_wdata;
      end
    end
  end

  // Read return: the RAM answers one cycle after the command. The tag picks
  // the port that receives the pulse. Reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= cmd_rd & ~cmd_tag;
      rvalid1 <= cmd_rd &  cmd_tag;
    end
  end

  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// tb_sample_mem_arbiter
//   Directed bench for sample_mem_arbiter. It contains a RAM stub and an
//   ownership/transaction model of the arbiter. Every negedge the DUT
//   outputs are compared against the model, and literal expectations pin
//   the model to hand-computed sequences.
module tb_sample_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  sample_mem_arbiter #(.addr_width(AW), .d_width(DW), .max_burst(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 25 MHz clock (40 ns period).
  always #20 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return 16'(16'hC000 + a);
  endfunction

  // RAM stub: synchronous single-port memory with a one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model state: owner (-1 means nobody), the port that wins the next tie,
  // the length of the current run, and the expected command/return streams.
  typedef struct {int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_t;
  typedef struct {int due; int port; logic [DW-1:0] data;} rv_t;

  int            cyc = 0;
  int            m_owner = -1;
  int            m_prefer = 0;
  int            m_run = 0;
  cmd_t          cmd_q[$];
  rv_t           rv_q[$];
  logic [DW-1:0] shadow [int];
  bit            r [2];
  int            other;

  function automatic logic [DW-1:0] shadow_read(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_prefer = 0; m_run = 0;
      cmd_q.delete(); rv_q.delete();
    end else begin
      cyc++;
      r[0] = req0; r[1] = req1;
      if (m_owner >= 0 && r[m_owner]) begin
        cmd_t c;
        c.due   = cyc + 1;
        c.we    = (m_owner == 0) ? we0 : we1;
        c.addr  = (m_owner == 0) ? addr0 : addr1;
        c.wdata = (m_owner == 0) ? wdata0 : wdata1;
        cmd_q.push_back(c);
        if (c.we) shadow[int'(c.addr)] = c.wdata;
        else rv_q.push_back('{due: cyc + 2, port: m_owner, data: shadow_read(int'(c.addr))});
      end
      if (m_owner < 0) begin
        if (r[0] && r[1]) m_owner = m_prefer;
        else if (r[0])    m_owner = 0;
        else if (r[1])    m_owner = 1;
      end else begin
        other = 1 - m_owner;
        if (!r[m_owner]) begin
          m_prefer = other;
          m_run    = 0;
          m_owner  = r[other] ? other : -1;
        end else begin
          m_run++;
          if (m_run == MB) begin
            m_run = 0;
            if (r[other]) begin
              m_prefer = other;
              m_owner  = other;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, outputs against the model.
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          e_en, e_we, e_rv0, e_rv1;
  logic [DW-1:0] e_rdata;
  cmd_t          cc;
  rv_t           vv;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_addr = '0; hold_wdata = '0;
      checkOutput("rst_gnt0", gnt0, 0);
      checkOutput("rst_gnt1", gnt1, 0);
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_rvalid0", rvalid0, 0);
      checkOutput("rst_rvalid1", rvalid1, 0);
    end else begin
      e_en = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0; e_rdata = '0;
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        cc = cmd_q.pop_front();
        e_en = 1; e_we = cc.we; hold_addr = cc.addr; hold_wdata = cc.wdata;
      end
      if (rv_q.size() > 0 && rv_q[0].due == cyc) begin
        vv = rv_q.pop_front();
        e_rdata = vv.data;
        if (vv.port == 0) e_rv0 = 1; else e_rv1 = 1;
      end
      checkOutput("gnt0", gnt0, (m_owner == 0));
      checkOutput("gnt1", gnt1, (m_owner == 1));
      checkOutput("mem_en", mem_en, e_en);
      checkOutput("mem_we", mem_we, e_we);
      checkOutput("mem_addr", mem_addr, hold_addr);
      checkOutput("mem_wdata", mem_wdata, hold_wdata);
      checkOutput("rvalid0", rvalid0, e_rv0);
      checkOutput("rvalid1", rvalid1, e_rv1);
      if (e_rv0) checkOutput("rdata0", rdata0, e_rdata);
      if (e_rv1) checkOutput("rdata1", rdata1, e_rdata);
    end
  end

  // DUT-side logs used for the hand-computed literal expectations.
  // acc_log holds, for each edge, the port accepted there (2 means none).
  typedef struct {int cyc; int port; logic [DW-1:0] data;} rvlog_t;
  int     acc_log[$];
  rvlog_t rv_log[$];

  always @(posedge clk) begin
    if (reset_n) acc_log.push_back((gnt0 && req0) ? 0 : ((gnt1 && req1) ? 1 : 2));
  end

  always @(negedge clk) begin
    if (rvalid0) rv_log.push_back('{cyc: cyc, port: 0, data: rdata0});
    if (rvalid1) rv_log.push_back('{cyc: cyc, port: 1, data: rdata1});
  end

  // Present one beat on port p and wait (bounded) until it is accepted.
  // Called at posedge+2. Returns at posedge+2, with req still high.
  task automatic applyStimulus(input int p, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    logic g;
    bit   ok = 0;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      g = (p == 0) ? gnt0 : gnt1;
      @(posedge clk);
      if (g) ok = 1;
    end
    checkOutput($sformatf("accept_p%0d_a%0d", p, a), ok, 1);
    if (!ok) begin
      if (p == 0) req0 = 0; else req1 = 0;
    end
    #2;
  endtask

  initial begin
    #(40 * 20000);
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_pat [10] = '{2, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    reset_n = 0;
    req0 = 1; we0 = 1; addr0 = 15'd3; wdata0 = 16'hAAAA;
    req1 = 1; we1 = 1; addr1 = 15'd4; wdata1 = 16'hBBBB;

    // Reset held with both requests high, then contention.
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    acc_log.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("first_gnt0", gnt0, 1);
    checkOutput("first_gnt1", gnt1, 0);
    repeat (9) @(posedge clk);
    #2 req0 = 0; req1 = 0;
    checkOutput("contention_len", (acc_log.size() >= 10), 1);
    for (int i = 0; i < 10 && i < acc_log.size(); i++)
      checkOutput($sformatf("contention_beat%0d", i), acc_log[i], exp_pat[i]);
    repeat (6) @(posedge clk);
    #2;

    // Single write, then read back from port 0.
    rv_log.delete();
    applyStimulus(0, 1, 15'd5, 16'h1234);
    applyStimulus(0, 0, 15'd5, 16'h0000);
    req0 = 0;
    repeat (6) @(posedge clk);
    #2;
    checkOutput("wr_rd_count", rv_log.size(), 1);
    if (rv_log.size() >= 1) begin
      checkOutput("wr_rd_port", rv_log[0].port, 0);
      checkOutput("wr_rd_data", rv_log[0].data, 16'h1234);
    end

    // Ten beats on port 0 with no competitor: contiguous, no gaps.
    acc_log.delete();
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, AW'(100 + i), DW'(i * 16'h0011));
    req0 = 0;
    checkOutput("solo_len", (acc_log.size() >= 11), 1);
    if (acc_log.size() >= 11) begin
      checkOutput("solo_arb_gap", acc_log[0], 2);
      for (int i = 1; i <= 10; i++) checkOutput($sformatf("solo_beat%0d", i), acc_log[i], 0);
    end
    repeat (6) @(posedge clk);
    #2;

    // Read tagging: port 1 reads 7 and 8, then port 0 reads 9.
    rv_log.delete();
    applyStimulus(1, 0, 15'd7, 16'h0000);
    applyStimulus(1, 0, 15'd8, 16'h0000);
    req1 = 0;
    applyStimulus(0, 0, 15'd9, 16'h0000);
    req0 = 0;
    repeat (6) @(posedge clk);
    #2;
    checkOutput("tag_count", rv_log.size(), 3);
    if (rv_log.size() >= 3) begin
      checkOutput("tag_port0", rv_log[0].port, 1);
      checkOutput("tag_data0", rv_log[0].data, 16'hC007);
      checkOutput("tag_port1", rv_log[1].port, 1);
      checkOutput("tag_data1", rv_log[1].data, 16'hC008);
      checkOutput("tag_port2", rv_log[2].port, 0);
      checkOutput("tag_data2", rv_log[2].data, 16'hC009);
      checkOutput("tag_b2b", rv_log[1].cyc - rv_log[0].cyc, 1);
    end

    // Reset one cycle after a port 1 read is accepted.
    rv_log.delete();
    applyStimulus(1, 0, 15'd7, 16'h0000);
    req1 = 0;
    @(posedge clk);
    #2 reset_n = 0;
    req0 = 1; we0 = 0; addr0 = 15'd20;
    req1 = 1; we1 = 0; addr1 = 15'd21;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_no_rvalid", rv_log.size(), 0);
    checkOutput("rst_mid_tie_gnt0", gnt0, 1);
    checkOutput("rst_mid_tie_gnt1", gnt1, 0);
    repeat (3) @(posedge clk);
    #2 req0 = 0; req1 = 0;
    repeat (8) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_mem_arbiter.md
Name: sample_mem_arbiter

Overview:
- Shares one single-port synchronous sample RAM (delay/echo line) between two requesters on the 25 MHz effect clock domain.
- Port 0 is the effect write path (stores incoming samples); port 1 is the effect tap-read path.
- Round-robin arbitration with a per-owner burst limit, registered memory command and a tagged read-return pipeline.
- Sits between effect_module's delay effects and the BRAM primitive.

Parameters:
- addr_width, 15, sample RAM address width (32768 samples)
- d_width, 16, sample width (matches memory_d_width)
- max_burst, 4, maximum consecutive accepted beats per owner while the other port is requesting (≥1)

Ports:
- clk  in  1  effect-domain clock (25 MHz)
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until accepted
- we0  in  1  port 0: 1 = write, 0 = read
- addr0  in  addr_width  port 0 address
- wdata0  in  d_width  port 0 write data
- gnt0  out  1  port 0 grant; req0 & gnt0 at a rising edge = beat accepted
- rvalid0  out  1  port 0 read data valid, one-cycle pulse
- rdata0  out  d_width  port 0 read data (mem_rdata pass-through, qualified by rvalid0)
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  addr_width  RAM address
- mem_wdata  out  d_width  RAM write data
- mem_rdata  in  d_width  RAM read data, valid one cycle after a read command

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; gnt0/gnt1, mem_en, mem_we, rvalid0/rvalid1 = 0; mem_addr, mem_wdata = 0.
  - burst_cnt = 0; last_owner = 1, so port 0 wins the first tie.
  - In-flight reads are discarded; no rvalid is issued after reset.
- FSM states IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both registered.
- IDLE:
  - req0 & req1 → OWN of the port ≠ last_owner.
  - Only one req → OWN of that port.
  - Neither → stay in IDLE.
  - One cycle of arbitration latency from req to gnt.
- OWNx, per edge:
  - If reqx is high, the beat is accepted and burst_cnt increments.
  - Leave OWNx when reqx=0: go to OWNy if reqy, else IDLE.
  - Leave OWNx when the accepted beat brings burst_cnt to max_burst and reqy=1: go to OWNy.
  - Burst limit reached and reqy=0: stay in OWNx, burst_cnt = 0.
  - On every state change, burst_cnt = 0 and last_owner = x.
- Command register: on an accepted beat, the next cycle drives mem_en=1, mem_we=wex, mem_addr=addrx, mem_wdata=wdatax. Otherwise mem_en=0 and mem_we=0; addr/wdata hold their previous values.
- Read return:
  - The read owner tag is pipelined alongside the command.
  - rvalidx pulses for exactly one cycle, two cycles after acceptance: edge E accept → E+1 command presented → E+2 RAM data → rvalidx high during cycle E+2..E+3.
  - Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses, in acceptance order.
- Throughput: one beat per cycle while ownership is held; switching owners costs 0 cycles (OWN0→OWN1 direct). IDLE→OWN costs 1 cycle.
- Dropping req: a requester may drop req only after acceptance. A req dropped before grant is not an error; no beat is issued.
- Simultaneous events:
  - Owner drops req on the same edge the burst limit would trigger: the reqx=0 rule applies.
  - Both ports idle in OWN: go to IDLE.
- Width rules: addresses and data pass through unmodified; no arithmetic on the datapath. burst_cnt is sized as clog2(max_burst)+1 bits and never wraps past max_burst.

Test Plan:
- Reset: hold reset_n=0 with req0=req1=1 → gnt0=gnt1=mem_en=rvalid0/1=0. After release, first grant is gnt0, one cycle after the first edge.
- Single write then read: port 0 writes 0x1234 @ addr 5, then reads addr 5 → one mem_en/mem_we=1 cycle with mem_addr=5 and mem_wdata=0x1234. Read gives rvalid0 2 cycles after acceptance with rdata0=0x1234. rvalid1 stays 0.
- Contention with max_burst=4: req0 and req1 held continuously → accepted beat pattern 0,0,0,0,1,1,1,1,0,… with no idle cycle between groups.
- Burst limit with no competitor: only req0 held for 10 beats → gnt0 stays high, 10 consecutive accepted beats, no gap.
- Read tagging: port 1 reads addrs 7, 8 back-to-back, then port 0 reads addr 9 → rvalid1, rvalid1, rvalid0 in that order, rdata matching RAM contents, each pulse exactly 1 cycle.
- Reset mid-operation: assert reset_n=0 one cycle after a port 1 read is accepted → rvalid1 never asserts. After release, state is IDLE and port 0 wins a tie.
